// File: rtl/jt12_eg_pkg.sv
// Shared types, constants and helpers for the jt12 ADSR envelope generator.
package jt12_eg_pkg;

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } eg_state_e;

    localparam logic [9:0] EG_MAX = 10'h3FF;

    // Entry i is the 8-tick increment pattern selected by rate[1:0] == i.
    localparam logic [3:0][7:0] STEP_PAT = {
        8'b11111110,
        8'b11101110,
        8'b11101010,
        8'b10101010
    };

    function automatic logic [9:0] sl_level(input logic [3:0] sl);
        logic [4:0] lvl;
        lvl = (sl == 4'hF) ? 5'h1F : {1'b0, sl};
        return {lvl, 5'b0};
    endfunction

endpackage

// File: rtl/jt12_eg_step.sv
// Combinational rate scaler and per-tick envelope step selector.
module jt12_eg_step
    import jt12_eg_pkg::*;
(
    input  logic [4:0]  base_rate,
    input  logic [1:0]  ks,
    input  logic [4:0]  keycode,
    input  logic [14:0] eg_cnt,
    output logic [5:0]  rate,
    output logic [4:0]  step
);

    logic [6:0]  rate_sum;
    logic [7:0]  pat;
    logic [3:0]  sh;
    logic [14:0] mask;
    logic [2:0]  pat_idx;

    always_comb begin
        rate_sum = {1'b0, base_rate, 1'b0} + 7'(keycode >> (2'd3 - ks));
        rate     = 6'd0;
        if (base_rate != 5'd0) begin
            rate = (rate_sum > 7'd63) ? 6'd63 : rate_sum[5:0];
        end
        pat     = STEP_PAT[rate[1:0]];
        // sh only matters below rate 48, where rate[5:2] <= 11
        sh      = 4'd11 - rate[5:2];
        mask    = (15'd1 << sh) - 15'd1;
        pat_idx = 3'(eg_cnt >> sh);
        step    = 5'd0;
        if (rate != 6'd0) begin
            if (rate < 6'd48) begin
                if ((eg_cnt & mask) == 15'd0) begin
                    step = {4'd0, pat[pat_idx]};
                end
            end else begin
                step = 5'd1 << ({1'b0, rate[3:2]} + {2'b0, pat[eg_cnt[2:0]]});
            end
        end
    end

endmodule

// File: rtl/jt12_eg_adsr.sv
// Single-operator ADSR envelope generator producing pre-TL attenuation.
// Define JT12_EG_RATE_OUT_EN to expose the registered effective rate on eg_rate.
module jt12_eg_adsr
    import jt12_eg_pkg::*;
#(
    parameter int EG_DIV = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       keyon,
    input  logic [4:0] ar,
    input  logic [4:0] d1r,
    input  logic [4:0] d2r,
    input  logic [3:0] rr,
    input  logic [3:0] sl,
    input  logic [1:0] ks,
    input  logic [4:0] keycode,
    output logic [9:0] eg_pream,
    output logic [1:0] eg_state
`ifdef JT12_EG_RATE_OUT_EN
    ,
    output logic [5:0] eg_rate
`endif
);

    localparam logic [2:0] DIV_LAST = 3'(EG_DIV - 1);

    logic [2:0]  div_q, div_d;
    logic [14:0] cnt_q, cnt_d;
    logic        keyon_last_q, keyon_last_d;
    eg_state_e   state_q, state_d;
    logic [9:0]  eg_q, eg_d;
    logic [4:0]  base_rate;
    logic [5:0]  rate;
    logic [4:0]  step;
    logic        tick;

    function automatic logic [9:0] sat_add(input logic [9:0] eg, input logic [4:0] stp);
        logic [10:0] sum;
        sum = {1'b0, eg} + {6'd0, stp};
        return (sum > {1'b0, EG_MAX}) ? EG_MAX : sum[9:0];
    endfunction

    // Exponential attack approach towards 0, clamped so large steps cannot underflow.
    function automatic logic [9:0] atk_sub(input logic [9:0] eg, input logic [4:0] stp);
        logic        [14:0] prod;
        logic signed [11:0] res;
        prod = {5'd0, eg} * {10'd0, stp};
        res  = $signed({2'b0, eg}) - $signed({1'b0, prod[14:4]})
             - (((stp != 5'd0) && (eg != 10'd0)) ? 12'sd1 : 12'sd0);
        return (res < 12'sd0) ? 10'd0 : res[9:0];
    endfunction

    always_comb begin
        case (state_q)
            ST_ATTACK:  base_rate = ar;
            ST_DECAY:   base_rate = d1r;
            ST_SUSTAIN: base_rate = d2r;
            default:    base_rate = {rr, 1'b1};
        endcase
    end

    jt12_eg_step u_step (
        .base_rate (base_rate),
        .ks        (ks),
        .keycode   (keycode),
        .eg_cnt    (cnt_q),
        .rate      (rate),
        .step      (step)
    );

    assign tick = cen && (div_q == DIV_LAST);

    always_comb begin
        div_d        = div_q;
        cnt_d        = cnt_q;
        keyon_last_d = keyon_last_q;
        state_d      = state_q;
        eg_d         = eg_q;
        if (cen) begin
            keyon_last_d = keyon;
            div_d        = tick ? 3'd0 : div_q + 3'd1;
            if (tick) begin
                cnt_d = cnt_q + 15'd1;
            end
            // Key edges override any tick-driven level or state change this cycle
            if (keyon && !keyon_last_q) begin
                state_d = ST_ATTACK;
            end else if (!keyon && keyon_last_q) begin
                state_d = ST_RELEASE;
            end else if (tick) begin
                case (state_q)
                    ST_ATTACK: begin
                        if (rate >= 6'd62) begin
                            eg_d    = 10'd0;
                            state_d = ST_DECAY;
                        end else begin
                            eg_d = atk_sub(eg_q, step);
                            if (eg_d == 10'd0) begin
                                state_d = ST_DECAY;
                            end
                        end
                    end
                    ST_DECAY: begin
                        eg_d = sat_add(eg_q, step);
                        if (eg_d >= sl_level(sl)) begin
                            state_d = ST_SUSTAIN;
                        end
                    end
                    default: eg_d = sat_add(eg_q, step);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= 3'd0;
            cnt_q        <= 15'd0;
            keyon_last_q <= 1'b0;
            state_q      <= ST_RELEASE;
            eg_q         <= EG_MAX;
        end else begin
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            keyon_last_q <= keyon_last_d;
            state_q      <= state_d;
            eg_q         <= eg_d;
        end
    end

`ifdef JT12_EG_RATE_OUT_EN
    logic [5:0] rate_q, rate_d;

    always_comb begin
        rate_d = rate_q;
        if (cen) begin
            rate_d = rate;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q <= 6'd0;
        end else begin
            rate_q <= rate_d;
        end
    end

    assign eg_rate = rate_q;
`endif

    assign eg_pream = eg_q;
    assign eg_state = state_q;

endmodule
